// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the 5-stage core.
//
// Arbitrates stall and redirect requests from ID, EX and MEM. Drives per-stage
// hold and flush enables, detects branch mispredictions at EX, and supplies
// the corrected fetch address to the PC.
//
// Ports:
//   clk, rstn          core clock, asynchronous active-low reset
//   id_lu_hazard_i     load-use hazard between ID and EX
//   ex_*_i             EX-stage branch resolution and multi-cycle op handshake
//   mem_wait_i         data bus not ready
//   hold_en_o[4:0]     hold per stage: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
//   flush_o[4:0]       bubble insert into the same registers as hold_en_o
//   prd_fail_o         misprediction redirect this cycle
//   redirect_addr_o    corrected PC
//   err_o              sticky multi-cycle watchdog error
//   mispred_cnt_o      mispredictions retired
//   stall_cnt_o        cycles with the PC held
//
// Configuration: define PIPE_CTRL_PERF_CNT_EN to build the performance
// counters; otherwise both counter outputs are tied to zero.

module pipe_ctrl #(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_lu_hazard_i,
    input  logic             ex_valid_i,
    input  logic             ex_branch_i,
    input  logic             ex_jump_en_i,
    input  logic             ex_prd_taken_i,
    input  logic [31:0]      ex_prd_addr_i,
    input  logic [31:0]      ex_jump_addr_i,
    input  logic [31:0]      ex_instaddr_i,
    input  logic             ex_mc_req_i,
    input  logic             ex_mc_done_i,
    input  logic             mem_wait_i,
    output logic [4:0]       hold_en_o,
    output logic [4:0]       flush_o,
    output logic             prd_fail_o,
    output logic [31:0]      redirect_addr_o,
    output logic             err_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned WdW = $clog2(MC_TIMEOUT);

    typedef enum logic [1:0] {
        StRun,
        StMcWait,
        StRedir
    } state_e;

    state_e         state_q, state_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    logic           mp;
    logic           wd_expired;

    assign mp = ex_valid_i & ex_branch_i &
                ((ex_jump_en_i != ex_prd_taken_i) |
                 (ex_jump_en_i & ex_prd_taken_i & (ex_jump_addr_i != ex_prd_addr_i)));

    assign redirect_addr_o = ex_jump_en_i ? ex_jump_addr_i : ex_instaddr_i + 32'd4;

    assign wd_expired = (wd_q == WdW'(MC_TIMEOUT - 1));

    always_comb begin
        hold_en_o  = 5'b00000;
        flush_o    = 5'b00000;
        prd_fail_o = 1'b0;
        state_d    = state_q;
        wd_d       = wd_q;
        err_d      = err_q;

        unique case (state_q)
            StRun: begin
                if (mem_wait_i) begin
                    // EX is frozen; any pending request is re-evaluated next cycle.
                    hold_en_o = 5'b01111;
                    flush_o   = 5'b10000;
                end else if (ex_mc_req_i) begin
                    hold_en_o = 5'b00111;
                    flush_o   = 5'b01000;
                    wd_d      = '0;
                    state_d   = StMcWait;
                end else if (mp) begin
                    // Beats load-use: the ID instruction is on the wrong path.
                    prd_fail_o = 1'b1;
                    flush_o    = 5'b00110;
                    state_d    = StRedir;
                end else if (id_lu_hazard_i) begin
                    hold_en_o = 5'b00011;
                    flush_o   = 5'b00100;
                end
            end

            StMcWait: begin
                if (ex_mc_done_i || wd_expired) begin
                    // Release the pipeline; a timeout without done is latched as an error.
                    wd_d    = '0;
                    state_d = StRun;
                    if (!ex_mc_done_i) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (mem_wait_i) begin
                        hold_en_o = 5'b01111;
                        flush_o   = 5'b10000;
                    end else begin
                        hold_en_o = 5'b00111;
                        flush_o   = 5'b01000;
                    end
                end
            end

            StRedir: begin
                if (mem_wait_i) begin
                    hold_en_o = 5'b01111;
                    flush_o   = 5'b10000;
                end else begin
                    // Discard the wrong-path fetch already in flight.
                    flush_o = 5'b00010;
                    state_d = StRun;
                end
            end

            default: begin
                state_d = StRun;
            end
        endcase

        if (!rstn) begin
            hold_en_o  = 5'b00000;
            flush_o    = 5'b11111;
            prd_fail_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StRun;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] mispred_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mispred_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            mispred_cnt_q <= mispred_cnt_q + CNT_W'(prd_fail_o);
            stall_cnt_q   <= stall_cnt_q + CNT_W'(hold_en_o[0]);
        end
    end

    assign mispred_cnt_o = mispred_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;
`else
    assign mispred_cnt_o = '0;
    assign stall_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl.
//
// A behavioural model tracks whether a divide is outstanding, whether a
// redirect bubble is pending, and the error/counter values; a compare process
// checks every DUT output against it on each falling edge. Directed scenarios
// also pin hand-computed literal values.

module tb_pipe_ctrl;

    localparam int unsigned McTimeout = 64;
    localparam int unsigned CntW      = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            id_lu_hazard_i = 1'b0;
    logic            ex_valid_i = 1'b0;
    logic            ex_branch_i = 1'b0;
    logic            ex_jump_en_i = 1'b0;
    logic            ex_prd_taken_i = 1'b0;
    logic [31:0]     ex_prd_addr_i = '0;
    logic [31:0]     ex_jump_addr_i = '0;
    logic [31:0]     ex_instaddr_i = '0;
    logic            ex_mc_req_i = 1'b0;
    logic            ex_mc_done_i = 1'b0;
    logic            mem_wait_i = 1'b0;
    logic [4:0]      hold_en_o;
    logic [4:0]      flush_o;
    logic            prd_fail_o;
    logic [31:0]     redirect_addr_o;
    logic            err_o;
    logic [CntW-1:0] mispred_cnt_o;
    logic [CntW-1:0] stall_cnt_o;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .MC_TIMEOUT(McTimeout),
        .CNT_W     (CntW)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .id_lu_hazard_i (id_lu_hazard_i),
        .ex_valid_i     (ex_valid_i),
        .ex_branch_i    (ex_branch_i),
        .ex_jump_en_i   (ex_jump_en_i),
        .ex_prd_taken_i (ex_prd_taken_i),
        .ex_prd_addr_i  (ex_prd_addr_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .ex_instaddr_i  (ex_instaddr_i),
        .ex_mc_req_i    (ex_mc_req_i),
        .ex_mc_done_i   (ex_mc_done_i),
        .mem_wait_i     (mem_wait_i),
        .hold_en_o      (hold_en_o),
        .flush_o        (flush_o),
        .prd_fail_o     (prd_fail_o),
        .redirect_addr_o(redirect_addr_o),
        .err_o          (err_o),
        .mispred_cnt_o  (mispred_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_div_busy;
    bit          m_redir_pending;
    int          m_div_cycles;
    logic        m_err;
    logic [31:0] m_mp_cnt;
    logic [31:0] m_st_cnt;

    function automatic bit mispredicted();
        if (!(ex_valid_i && ex_branch_i)) return 1'b0;
        if (ex_jump_en_i != ex_prd_taken_i) return 1'b1;
        return ex_jump_en_i && (ex_jump_addr_i != ex_prd_addr_i);
    endfunction

    function automatic void exp_out(output logic [4:0] h, output logic [4:0] f,
                                    output logic pf, output logic [31:0] ra);
        h  = 5'b00000;
        f  = 5'b00000;
        pf = 1'b0;
        ra = ex_jump_en_i ? ex_jump_addr_i : ex_instaddr_i + 32'd4;
        if (!rstn) begin
            f = 5'b11111;
        end else if (m_div_busy) begin
            if (!(ex_mc_done_i || m_div_cycles == McTimeout - 1)) begin
                h = mem_wait_i ? 5'b01111 : 5'b00111;
                f = mem_wait_i ? 5'b10000 : 5'b01000;
            end
        end else if (mem_wait_i) begin
            h = 5'b01111;
            f = 5'b10000;
        end else if (m_redir_pending) begin
            f = 5'b00010;
        end else if (ex_mc_req_i) begin
            h = 5'b00111;
            f = 5'b01000;
        end else if (mispredicted()) begin
            pf = 1'b1;
            f  = 5'b00110;
        end else if (id_lu_hazard_i) begin
            h = 5'b00011;
            f = 5'b00100;
        end
    endfunction

    always @(posedge clk or negedge rstn) begin
        logic [4:0]  h;
        logic [4:0]  f;
        logic        pf;
        logic [31:0] ra;
        if (!rstn) begin
            m_div_busy      = 1'b0;
            m_redir_pending = 1'b0;
            m_div_cycles    = 0;
            m_err           = 1'b0;
            m_mp_cnt        = '0;
            m_st_cnt        = '0;
        end else begin
            exp_out(h, f, pf, ra);
            m_mp_cnt = m_mp_cnt + 32'(pf);
            m_st_cnt = m_st_cnt + 32'(h[0]);
            if (m_div_busy) begin
                if (ex_mc_done_i) begin
                    m_div_busy = 1'b0;
                end else if (m_div_cycles == McTimeout - 1) begin
                    m_div_busy = 1'b0;
                    m_err      = 1'b1;
                end else begin
                    m_div_cycles++;
                end
            end else if (mem_wait_i) begin
                // frozen
            end else if (m_redir_pending) begin
                m_redir_pending = 1'b0;
            end else if (ex_mc_req_i) begin
                m_div_busy   = 1'b1;
                m_div_cycles = 0;
            end else if (mispredicted()) begin
                m_redir_pending = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [4:0]  h;
        logic [4:0]  f;
        logic        pf;
        logic [31:0] ra;
        exp_out(h, f, pf, ra);
        chk("cmp_hold", 32'(hold_en_o), 32'(h));
        chk("cmp_flush", 32'(flush_o), 32'(f));
        chk("cmp_prd_fail", 32'(prd_fail_o), 32'(pf));
        chk("cmp_redirect", redirect_addr_o, ra);
        chk("cmp_err", 32'(err_o), 32'(m_err));
`ifdef PIPE_CTRL_PERF_CNT_EN
        chk("cmp_mispred_cnt", mispred_cnt_o, m_mp_cnt);
        chk("cmp_stall_cnt", stall_cnt_o, m_st_cnt);
`else
        chk("cmp_mispred_cnt", mispred_cnt_o, 32'd0);
        chk("cmp_stall_cnt", stall_cnt_o, 32'd0);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        id_lu_hazard_i = 1'b0;
        ex_valid_i     = 1'b0;
        ex_branch_i    = 1'b0;
        ex_jump_en_i   = 1'b0;
        ex_prd_taken_i = 1'b0;
        ex_prd_addr_i  = '0;
        ex_jump_addr_i = '0;
        ex_instaddr_i  = '0;
        ex_mc_req_i    = 1'b0;
        ex_mc_done_i   = 1'b0;
        mem_wait_i     = 1'b0;
    endtask

    task automatic br(input logic jen, input logic ptk, input logic [31:0] paddr,
                      input logic [31:0] jaddr, input logic [31:0] iaddr);
        ex_valid_i     = 1'b1;
        ex_branch_i    = 1'b1;
        ex_jump_en_i   = jen;
        ex_prd_taken_i = ptk;
        ex_prd_addr_i  = paddr;
        ex_jump_addr_i = jaddr;
        ex_instaddr_i  = iaddr;
    endtask

    initial begin
        // Reset state
        mid();
        chk("rst_hold", 32'(hold_en_o), 32'h00);
        chk("rst_flush", 32'(flush_o), 32'h1f);
        chk("rst_prd_fail", 32'(prd_fail_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        next_cycle();
        rstn = 1'b1;

        mid();
        chk("idle_hold", 32'(hold_en_o), 32'h00);
        chk("idle_flush", 32'(flush_o), 32'h00);
        next_cycle();

        // Predicted not-taken, taken to 0x100
        br(1'b1, 1'b0, 32'h0, 32'h100, 32'h40);
        mid();
        chk("mp_nt_prd_fail", 32'(prd_fail_o), 32'd1);
        chk("mp_nt_redirect", redirect_addr_o, 32'h100);
        chk("mp_nt_flush", 32'(flush_o), 32'h06);
        next_cycle();
        clr();
        mid();
        chk("redir_flush", 32'(flush_o), 32'h02);
        chk("redir_prd_fail", 32'(prd_fail_o), 32'd0);
`ifdef PIPE_CTRL_PERF_CNT_EN
        chk("mispred_cnt_1", mispred_cnt_o, 32'd1);
`endif
        next_cycle();
        mid();
        chk("post_redir_flush", 32'(flush_o), 32'h00);
        next_cycle();

        // Predicted taken to 0x200, actually taken to 0x240
        br(1'b1, 1'b1, 32'h200, 32'h240, 32'h80);
        mid();
        chk("mp_tgt_prd_fail", 32'(prd_fail_o), 32'd1);
        chk("mp_tgt_redirect", redirect_addr_o, 32'h240);
        next_cycle();
        clr();
        next_cycle();

        // Correct taken prediction
        br(1'b1, 1'b1, 32'h300, 32'h300, 32'h90);
        mid();
        chk("ok_t_prd_fail", 32'(prd_fail_o), 32'd0);
        chk("ok_t_flush", 32'(flush_o), 32'h00);
        next_cycle();

        // Correct not-taken at the top of the address space: fall-through wraps
        br(1'b0, 1'b0, 32'h0, 32'h1234, 32'hFFFF_FFFC);
        mid();
        chk("ok_nt_prd_fail", 32'(prd_fail_o), 32'd0);
        chk("ok_nt_redirect_wrap", redirect_addr_o, 32'h0);
        next_cycle();

        // Predicted taken, actually not taken
        br(1'b0, 1'b1, 32'h500, 32'h0, 32'h80);
        mid();
        chk("mp_tn_prd_fail", 32'(prd_fail_o), 32'd1);
        chk("mp_tn_redirect", redirect_addr_o, 32'h84);
        next_cycle();
        clr();
        next_cycle();

        // Mismatch on an invalid EX slot is not a misprediction
        br(1'b1, 1'b0, 32'h0, 32'h100, 32'h40);
        ex_valid_i = 1'b0;
        mid();
        chk("inv_prd_fail", 32'(prd_fail_o), 32'd0);
        next_cycle();
        clr();

        // Multi-cycle op with done five cycles after the request
        ex_mc_req_i = 1'b1;
        mid();
        chk("mc_req_hold", 32'(hold_en_o), 32'h07);
        chk("mc_req_flush", 32'(flush_o), 32'h08);
        next_cycle();
        clr();
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("mc_wait_hold", 32'(hold_en_o), 32'h07);
            next_cycle();
        end
        ex_mc_done_i = 1'b1;
        mid();
        chk("mc_done_hold", 32'(hold_en_o), 32'h00);
        chk("mc_done_flush", 32'(flush_o), 32'h00);
        next_cycle();
        clr();
        mid();
        chk("mc_after_hold", 32'(hold_en_o), 32'h00);
`ifdef PIPE_CTRL_PERF_CNT_EN
        chk("stall_cnt_5", stall_cnt_o, 32'd5);
`endif
        next_cycle();

        // mem_wait during MC_WAIT
        ex_mc_req_i = 1'b1;
        next_cycle();
        clr();
        mem_wait_i = 1'b1;
        mid();
        chk("mc_memw_hold", 32'(hold_en_o), 32'h0f);
        chk("mc_memw_flush", 32'(flush_o), 32'h10);
        next_cycle();
        mem_wait_i = 1'b0;
        mid();
        chk("mc_nomemw_flush", 32'(flush_o), 32'h08);
        next_cycle();
        ex_mc_done_i = 1'b1;
        next_cycle();
        clr();

        // mem_wait concurrent with a misprediction for three cycles
        mem_wait_i = 1'b1;
        br(1'b1, 1'b0, 32'h0, 32'h100, 32'h40);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("memw_mp_hold", 32'(hold_en_o), 32'h0f);
            chk("memw_mp_prd_fail", 32'(prd_fail_o), 32'd0);
            next_cycle();
        end
        mem_wait_i = 1'b0;
        mid();
        chk("memw_drop_prd_fail", 32'(prd_fail_o), 32'd1);
        next_cycle();
        clr();
        mem_wait_i = 1'b1;
        mid();
        chk("redir_memw_hold", 32'(hold_en_o), 32'h0f);
        next_cycle();
        mem_wait_i = 1'b0;
        mid();
        chk("redir_late_flush", 32'(flush_o), 32'h02);
        next_cycle();

        // Load-use together with misprediction, then alone
        id_lu_hazard_i = 1'b1;
        br(1'b1, 1'b0, 32'h0, 32'h100, 32'h40);
        mid();
        chk("lu_mp_flush", 32'(flush_o), 32'h06);
        chk("lu_mp_hold", 32'(hold_en_o), 32'h00);
        next_cycle();
        clr();
        next_cycle();
        id_lu_hazard_i = 1'b1;
        mid();
        chk("lu_hold", 32'(hold_en_o), 32'h03);
        chk("lu_flush", 32'(flush_o), 32'h04);
        next_cycle();
        clr();
        mid();
        chk("lu_clear_hold", 32'(hold_en_o), 32'h00);
        next_cycle();

        // Watchdog: request with no done
        ex_mc_req_i = 1'b1;
        next_cycle();
        clr();
        for (int i = 0; i < McTimeout; i++) begin
            mid();
            chk("wd_hold", 32'(hold_en_o), (i == McTimeout - 1) ? 32'h00 : 32'h07);
            chk("wd_err_low", 32'(err_o), 32'd0);
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("wd_err_sticky", 32'(err_o), 32'd1);
            chk("wd_released", 32'(hold_en_o), 32'h00);
            next_cycle();
        end

        // Asynchronous reset in the middle of MC_WAIT
        ex_mc_req_i = 1'b1;
        next_cycle();
        clr();
        mid();
        chk("pre_rst_hold", 32'(hold_en_o), 32'h07);
        rstn = 1'b0;
        #1;
        chk("arst_flush", 32'(flush_o), 32'h1f);
        chk("arst_hold", 32'(hold_en_o), 32'h00);
        chk("arst_err", 32'(err_o), 32'd0);
        next_cycle();
        rstn = 1'b1;
        mid();
        chk("post_rst_hold", 32'(hold_en_o), 32'h00);
        chk("post_rst_flush", 32'(flush_o), 32'h00);
        next_cycle();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
